// File: rtl/enc_dec_rr_scheduler.sv
// enc_dec_rr_scheduler
// Shares one fixed-latency encoder/decoder core among four requester channels.
// Each cycle at most one eligible channel is granted in round-robin order. A
// {valid, id} tag follows every issued operation through the core latency so
// the result lands in the response register of the channel that issued it.
// A channel may have only one operation outstanding, from grant until its
// response is consumed, so a response register can never be overwritten.

module enc_dec_rr_scheduler #(
    parameter int DW   = 128,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic [3:0]      req_valid,
    input  logic [4*DW-1:0] req_data,
    output logic [3:0]      req_ready,
    output logic            core_in_valid,
    output logic [DW-1:0]   core_in_data,
    input  logic [DW-1:0]   core_out_data,
    output logic [3:0]      rsp_valid,
    output logic [4*DW-1:0] rsp_data,
    input  logic [3:0]      rsp_ready,
    output logic            idle,
    output logic [CNTW-1:0] issue_count
);

    // Scheduler state
    logic [3:0]              busy_r;
    logic [1:0]              ptr_r;
    logic [CNTW-1:0]         issue_count_r;
    logic [LAT-1:0]          tag_v_r;
    logic [LAT-1:0][1:0]     tag_id_r;
    logic [3:0]              rsp_valid_r;
    logic [3:0][DW-1:0]      rsp_data_r;

    // Grant decode
    logic [3:0]              eligible_s;
    logic [3:0]              grant_s;
    logic [1:0]              grant_id_s;
    logic                    grant_found_s;
    logic [1:0]              scan_idx_s;

    // Completion at the tail of the tag pipeline
    logic                    done_v_s;
    logic [1:0]              done_id_s;

    // Response handshake per channel
    logic [3:0]              rsp_fire_s;

    assign done_v_s   = tag_v_r[LAT-1];
    assign done_id_s  = tag_id_r[LAT-1];
    assign rsp_fire_s = rsp_valid_r & rsp_ready;

    // Round-robin pick: first eligible channel scanning from ptr upwards, wrapping.
    always_comb begin
        eligible_s    = req_valid & ~busy_r & {4{en}};
        grant_s       = 4'b0000;
        grant_id_s    = 2'd0;
        grant_found_s = 1'b0;
        scan_idx_s    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx_s = ptr_r + 2'(k);
            if (!grant_found_s && eligible_s[scan_idx_s]) begin
                grant_found_s        = 1'b1;
                grant_id_s           = scan_idx_s;
                grant_s[scan_idx_s]  = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Steer the granted channel's request data onto the core input.
    always_comb begin
        core_in_data = {DW{1'b0}};
        if (grant_found_s) begin
            case (grant_id_s)
                2'd0:    core_in_data = req_data[0*DW +: DW];
                2'd1:    core_in_data = req_data[1*DW +: DW];
                2'd2:    core_in_data = req_data[2*DW +: DW];
                2'd3:    core_in_data = req_data[3*DW +: DW];
                default: core_in_data = {DW{1'b0}};
            endcase
        end else begin
            core_in_data = {DW{1'b0}};
        end
    end

    assign req_ready     = grant_s;
    assign core_in_valid = grant_found_s;

    // Pointer and issue counter advance only on a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r         <= 2'd0;
            issue_count_r <= {CNTW{1'b0}};
        end else if (grant_found_s) begin
            ptr_r         <= grant_id_s + 2'd1;
            issue_count_r <= issue_count_r + CNTW'(1);
        end else begin
            ptr_r         <= ptr_r;
            issue_count_r <= issue_count_r;
        end
    end

    // Tag pipeline mirrors the core latency; it shifts every cycle because the core never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v_r  <= {LAT{1'b0}};
            tag_id_r <= '0;
        end else begin
            tag_v_r[0]  <= grant_found_s;
            tag_id_r[0] <= grant_id_s;
            for (int i = 1; i < LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Busy is set on grant and cleared when the channel's response is consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant_s[i]) begin
                    busy_r[i] <= 1'b1;
                end else if (rsp_fire_s[i]) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

    // Capture core results into the tagged channel; data is kept after the handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_r <= 4'b0000;
            rsp_data_r  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (done_v_s && (done_id_s == 2'(i))) begin
                    rsp_valid_r[i] <= 1'b1;
                    rsp_data_r[i]  <= core_out_data;
                end else if (rsp_fire_s[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end else begin
                    rsp_valid_r[i] <= rsp_valid_r[i];
                end
            end
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign issue_count = issue_count_r;
    assign idle        = ~|busy_r;

endmodule

// File: tb/tb_enc_dec_rr_scheduler.sv
// Directed bench for enc_dec_rr_scheduler with a LAT-cycle core model (data ^ 1).
`timescale 1ns/1ps

module tb_enc_dec_rr_scheduler;

    localparam int DW   = 128;
    localparam int LAT  = 2;
    localparam int CNTW = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [3:0]      req_valid = 4'b0000;
    logic [4*DW-1:0] req_data = '0;
    logic [3:0]      req_ready;
    logic            core_in_valid;
    logic [DW-1:0]   core_in_data;
    logic [DW-1:0]   core_out_data;
    logic [3:0]      rsp_valid;
    logic [4*DW-1:0] rsp_data;
    logic [3:0]      rsp_ready = 4'b0000;
    logic            idle;
    logic [CNTW-1:0] issue_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dat [4];
    logic [DW-1:0] core_pipe [LAT];
    logic [DW-1:0] one_w;

    enc_dec_rr_scheduler #(.DW(DW), .LAT(LAT), .CNTW(CNTW)) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .core_in_valid (core_in_valid),
        .core_in_data  (core_in_data),
        .core_out_data (core_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .idle          (idle),
        .issue_count   (issue_count)
    );

    always #5 clock = ~clock;

    // Core model: result is input ^ 1, presented exactly LAT cycles after issue.
    always @(posedge clock) begin
        core_pipe[0] <= core_in_valid ? core_in_data : '0;
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign one_w = {{(DW-1){1'b0}}, 1'b1};
    assign core_out_data = core_pipe[LAT-1] ^ one_w;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; en = 1'b0; req_valid = 4'b0000; rsp_ready = 4'b0000; req_data = '0;
        repeat (2) tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready c%0d: got %b expected 0000", c, req_ready); end
            checks++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL reset_core_in_valid c%0d: got %b expected 0", c, core_in_valid); end
            checks++; if (core_in_data !== '0) begin errors++; $display("FAIL reset_core_in_data c%0d: got %h expected 0", c, core_in_data); end
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid c%0d: got %b expected 0000", c, rsp_valid); end
            checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle c%0d: got %b expected 1", c, idle); end
            checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL reset_issue_count c%0d: got %0d expected 0", c, issue_count); end
        end
    endtask

    task automatic test_single;
        logic [DW-1:0] pat;
        logic [DW-1:0] res;
        pat = {8{16'hA5A5}};
        res = {{7{16'hA5A5}}, 16'hA5A4};
        tick;
        en = 1'b1; rsp_ready = 4'b1111; req_valid = 4'b0010; req_data = '0; req_data[1*DW +: DW] = pat;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", req_ready); end
        checks++; if (core_in_valid !== 1'b1) begin errors++; $display("FAIL single_core_in_valid: got %b expected 1", core_in_valid); end
        checks++; if (core_in_data !== pat) begin errors++; $display("FAIL single_core_in_data: got %h expected %h", core_in_data, pat); end
        tick;
        req_valid = 4'b0000;
        #1;
        checks++; if (issue_count !== 16'd1) begin errors++; $display("FAIL single_issue_count: got %0d expected 1", issue_count); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", idle); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early1: got %b expected 0000", rsp_valid); end
        tick; #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early2: got %b expected 0000", rsp_valid); end
        tick; #1;
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0010", rsp_valid); end
        checks++; if (rsp_data[1*DW +: DW] !== res) begin errors++; $display("FAIL single_rsp_data: got %h expected %h", rsp_data[1*DW +: DW], res); end
        tick; #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_consumed: got %b expected 0000", rsp_valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b expected 1", idle); end
        checks++; if (rsp_data[1*DW +: DW] !== res) begin errors++; $display("FAIL single_rsp_data_hold: got %h expected %h", rsp_data[1*DW +: DW], res); end
    endtask

    task automatic test_round_robin;
        logic [3:0] one4;
        logic [3:0] exp_v;
        int j;
        one4 = 4'b0001;
        do_reset;
        en = 1'b1; rsp_ready = 4'b1111; req_valid = 4'b1111;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (req_ready !== (one4 << (k % 4))) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", k, req_ready, one4 << (k % 4)); end
            checks++; if (core_in_data !== dat[k % 4]) begin errors++; $display("FAIL rr_core_in_data c%0d: got %h expected %h", k, core_in_data, dat[k % 4]); end
            checks++; if (issue_count !== 16'(k)) begin errors++; $display("FAIL rr_issue_count c%0d: got %0d expected %0d", k, issue_count, k); end
            exp_v = (k < 3) ? 4'b0000 : (one4 << ((k - 3) % 4));
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", k, rsp_valid, exp_v); end
            if (k >= 3) begin
                j = (k - 3) % 4;
                checks++; if (rsp_data[j*DW +: DW] !== (dat[j] ^ one_w)) begin errors++; $display("FAIL rr_rsp_data c%0d: got %h expected %h", k, rsp_data[j*DW +: DW], dat[j] ^ one_w); end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] exp_g [16];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b1000,
                  4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0100};
        do_reset;
        en = 1'b1; rsp_ready = 4'b1011; req_valid = 4'b1111;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        for (int k = 0; k < 16; k++) begin
            if (k == 14) rsp_ready = 4'b1111;
            #1;
            checks++; if (req_ready !== exp_g[k]) begin errors++; $display("FAIL bp_grant c%0d: got %b expected %b", k, req_ready, exp_g[k]); end
            if (k == 13 || k == 14) begin
                checks++; if (rsp_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid2_held c%0d: got %b expected 1", k, rsp_valid[2]); end
                checks++; if (rsp_data[2*DW +: DW] !== (dat[2] ^ one_w)) begin errors++; $display("FAIL bp_rsp_data2_held c%0d: got %h expected %h", k, rsp_data[2*DW +: DW], dat[2] ^ one_w); end
            end
            if (k == 15) begin
                checks++; if (rsp_valid[2] !== 1'b0) begin errors++; $display("FAIL bp_rsp_valid2_cleared: got %b expected 0", rsp_valid[2]); end
                checks++; if (issue_count !== 16'd12) begin errors++; $display("FAIL bp_issue_count: got %0d expected 12", issue_count); end
            end
            tick;
        end
    endtask

    task automatic test_enable;
        logic [3:0] exp_g [9];
        logic [3:0] exp_r [9];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
        exp_r = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        do_reset;
        en = 1'b1; rsp_ready = 4'b1111; req_valid = 4'b1111;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        for (int k = 0; k < 9; k++) begin
            if (k == 3) en = 1'b0;
            if (k == 7) en = 1'b1;
            #1;
            checks++; if (req_ready !== exp_g[k]) begin errors++; $display("FAIL en_grant c%0d: got %b expected %b", k, req_ready, exp_g[k]); end
            checks++; if (rsp_valid !== exp_r[k]) begin errors++; $display("FAIL en_rsp_valid c%0d: got %b expected %b", k, rsp_valid, exp_r[k]); end
            if (k >= 3 && k <= 6) begin
                checks++; if (core_in_data !== '0) begin errors++; $display("FAIL en_core_in_data_zero c%0d: got %h expected 0", k, core_in_data); end
            end
            if (k == 7) begin
                checks++; if (issue_count !== 16'd3) begin errors++; $display("FAIL en_issue_count: got %0d expected 3", issue_count); end
            end
            tick;
        end
    endtask

    task automatic test_reset_inflight;
        do_reset;
        en = 1'b1; rsp_ready = 4'b1111; req_valid = 4'b0011;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_if_grant0: got %b expected 0001", req_ready); end
        tick; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_if_grant1: got %b expected 0010", req_ready); end
        tick;
        reset = 1'b1; req_valid = 4'b0000;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_if_req_ready: got %b expected 0000", req_ready); end
        checks++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL rst_if_core_in_valid: got %b expected 0", core_in_valid); end
        checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL rst_if_issue_count: got %0d expected 0", issue_count); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_if_rsp_data: got nonzero expected 0"); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_if_rsp_valid c%0d: got %b expected 0000", c, rsp_valid); end
            checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_if_idle c%0d: got %b expected 1", c, idle); end
            tick;
        end
    endtask

    initial begin
        dat[0] = {4{32'h1111_0F0F}};
        dat[1] = {4{32'h2222_3C3C}};
        dat[2] = {4{32'h4444_5A5A}};
        dat[3] = {4{32'h8888_9696}};
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_enable;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
